// File: rtl/load_store_unit_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Width codes follow RV32I funct3; exception codes feed writeback.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_OK  = 2'b00;
  localparam logic [1:0] EXC_MIS = 2'b01;
  localparam logic [1:0] EXC_TMO = 2'b10;
  localparam logic [1:0] EXC_ILL = 2'b11;

  function automatic logic op_illegal(
    input logic       ld,
    input logic       st,
    input logic [2:0] f3
  );
    logic bad;
    bad = 1'b0;
    if (ld == st) begin
      bad = 1'b1;
    end else if (ld) begin
      bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end else begin
      bad = (f3 > F3_W);
    end
    return bad;
  endfunction

  function automatic logic addr_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store enables/replication and load
// extraction with sign or zero extension.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] mwdata,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    be      = 4'b1111;
    mwdata  = wdata;
    rdata   = '0;
    shifted = rword >> {off, 3'b000};
    if (we) begin
      case (funct3)
        F3_B: begin
          be     = 4'b0001 << off;
          mwdata = {4{wdata[7:0]}};
        end
        F3_H: begin
          be     = off[1] ? 4'b1100 : 4'b0011;
          mwdata = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata = shifted;
      F3_BU:   rdata = {24'b0, shifted[7:0]};
      F3_HU:   rdata = {16'b0, shifted[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one word-aligned req/ack access per op,
// stalls EX via o_Ready until writeback gets o_Done.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic                 i_Load,
  input  logic                 i_Store,
  input  logic [2:0]           i_Funct3,
  input  logic [WORD_SIZE-1:0] i_Addr,
  input  logic [WORD_SIZE-1:0] i_WData,
  output logic                 o_Done,
  output logic [WORD_SIZE-1:0] o_RData,
  output logic [1:0]           o_Exc,
  output logic                 o_MemReq,
  output logic                 o_MemWe,
  output logic [WORD_SIZE-1:0] o_MemAddr,
  output logic [WORD_SIZE-1:0] o_MemWData,
  output logic [3:0]           o_MemBe,
  input  logic                 i_MemAck,
  input  logic [WORD_SIZE-1:0] i_MemRData
);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [2:0]           f3_q, f3_d;
  logic                 we_q, we_d;
  logic [1:0]           exc_q, exc_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [3:0]           al_be;
  logic [WORD_SIZE-1:0] al_wdata;
  logic [WORD_SIZE-1:0] al_rdata;

  load_store_unit_align u_align (
    .we     (we_q),
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .rword  (i_MemRData),
    .be     (al_be),
    .mwdata (al_wdata),
    .rdata  (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_Valid) begin
          addr_d  = i_Addr;
          wdata_d = i_WData;
          f3_d    = i_Funct3;
          we_d    = i_Store;
          rdata_d = '0;
          cnt_d   = '0;
          if (op_illegal(i_Load, i_Store, i_Funct3)) begin
            exc_d   = EXC_ILL;
            state_d = S_RESP;
          end else if (addr_misaligned(i_Funct3, i_Addr[1:0])) begin
            exc_d   = EXC_MIS;
            state_d = S_RESP;
          end else begin
            exc_d   = EXC_OK;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // ack on the terminal count still completes normally
        if (i_MemAck) begin
          rdata_d = we_q ? '0 : al_rdata;
          state_d = S_RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          exc_d   = EXC_TMO;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      exc_q   <= EXC_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Ready    = (state_q == S_IDLE);
  assign o_Done     = (state_q == S_RESP);
  assign o_MemReq   = (state_q == S_REQ);
  assign o_MemWe    = o_MemReq & we_q;
  assign o_MemAddr  = o_MemReq ? {addr_q[WORD_SIZE-1:2], 2'b00} : '0;
  assign o_MemWData = o_MemReq ? al_wdata : '0;
  assign o_MemBe    = o_MemReq ? al_be : 4'b0000;
  assign o_RData    = rdata_q;
  assign o_Exc      = exc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Random + directed scoreboard bench for load_store_unit.
// Reference model derives responses from access size/offset arithmetic.
module tb_load_store_unit;

  localparam int T = 16;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_Valid = 1'b0;
  logic        i_Load = 1'b0;
  logic        i_Store = 1'b0;
  logic [2:0]  i_Funct3 = '0;
  logic [31:0] i_Addr = '0;
  logic [31:0] i_WData = '0;
  logic        i_MemAck = 1'b0;
  logic [31:0] i_MemRData = '0;
  logic        o_Ready, o_Done, o_MemReq, o_MemWe;
  logic [31:0] o_RData, o_MemAddr, o_MemWData;
  logic [1:0]  o_Exc;
  logic [3:0]  o_MemBe;

  load_store_unit #(.WORD_SIZE(32), .TIMEOUT(T)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .i_Load(i_Load), .i_Store(i_Store),
    .i_Funct3(i_Funct3), .i_Addr(i_Addr), .i_WData(i_WData),
    .o_Done(o_Done), .o_RData(o_RData), .o_Exc(o_Exc),
    .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr),
    .o_MemWData(o_MemWData), .o_MemBe(o_MemBe),
    .i_MemAck(i_MemAck), .i_MemRData(i_MemRData)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  exc;
    int          cyc;
  } resp_t;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    int          d;
    logic [31:0] word;
  } mem_t;

  resp_t sb[$];
  req_t  rq[$];
  mem_t  mq[$];
  int    n_vec = 0;
  int    n_bad = 0;
  bit    mon_en = 0;
  bit    late_ack = 0;
  logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] m_exc(input logic ld, input logic st,
                                       input logic [2:0] f3,
                                       input logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    if (ld == st) return 2'd3;
    if (ld && (f3 == 3'd3 || f3 > 3'd5)) return 2'd3;
    if (st && f3 > 3'd2) return 2'd3;
    if ((a % sz) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    int sz;
    logic [31:0] v, mask;
    sz   = 1 << f3[1:0];
    v    = w >> (8 * (a % 4));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v    = v & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic issue(input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int d,
                       input logic [31:0] w);
    int n = 0;
    int acc, sz;
    logic [1:0] e;
    resp_t r;
    req_t q;
    while (!o_Ready && n < 100) begin
      i_Valid  = 1'($urandom);
      i_Load   = 1'($urandom);
      i_Store  = 1'($urandom);
      i_Funct3 = 3'($urandom);
      i_Addr   = $urandom;
      i_WData  = $urandom;
      @(negedge i_Clk);
      n++;
    end
    if (n == 100) begin
      chk("ready_wait", 32'(o_Ready), 32'd1);
      i_Valid = 1'b0;
      return;
    end
    i_Valid  = 1'b1;
    i_Load   = ld;
    i_Store  = st;
    i_Funct3 = f3;
    i_Addr   = a;
    i_WData  = wd;
    acc = cyc + 1;
    e   = m_exc(ld, st, f3, a);
    sz  = 1 << f3[1:0];
    if (e != 2'd0) begin
      r = '{32'h0, e, acc};
    end else begin
      q.addr  = {a[31:2], 2'b00};
      q.we    = st;
      q.be    = st ? (4'((1 << sz) - 1) << a[1:0]) : 4'b1111;
      q.wdata = (sz == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                (sz == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
      rq.push_back(q);
      mq.push_back('{d, w});
      if (d < T) r = '{st ? 32'h0 : m_load(f3, a, w), 2'd0, acc + 1 + d};
      else       r = '{32'h0, 2'd2, acc + T};
    end
    sb.push_back(r);
    @(negedge i_Clk);
    i_Valid = 1'b0;
  endtask

  // memory model: acks after the queued delay, stray acks when idle
  mem_t m;
  bit   active = 0;
  int   k = 0;
  always @(negedge i_Clk) begin
    i_MemAck   = 1'b0;
    i_MemRData = $urandom;
    if (o_MemReq === 1'b1) begin
      if (!active && mq.size() > 0) begin
        m = mq.pop_front();
        active = 1;
        k = 0;
      end
      if (active && k == m.d) begin
        i_MemAck   = 1'b1;
        i_MemRData = m.word;
        active     = 0;
      end
      k++;
    end else begin
      active = 0;
      if (late_ack || ($urandom % 8) == 0) i_MemAck = 1'b1;
    end
  end

  req_t  cur;
  resp_t got;
  bit    in_req = 0;
  bit    cur_ok = 0;
  bit    prev_done = 0;
  always @(negedge i_Clk) begin
    if (mon_en) begin
      if (prev_done) chk("ready_after_done", 32'(o_Ready), 32'd1);
      prev_done = (o_Done === 1'b1);
      if (o_MemReq === 1'b1) begin
        if (!in_req) begin
          if (rq.size() == 0) begin
            chk("unexpected_req", 32'(o_MemReq), 32'd0);
            cur_ok = 0;
          end else begin
            cur = rq.pop_front();
            cur_ok = 1;
          end
        end
        in_req = 1;
        chk("ready_in_req", 32'(o_Ready), 32'd0);
        if (cur_ok) begin
          chk("mem_addr", o_MemAddr, cur.addr);
          chk("mem_we", 32'(o_MemWe), 32'(cur.we));
          chk("mem_be", 32'(o_MemBe), 32'(cur.be));
          if (cur.we) chk("mem_wdata", o_MemWData, cur.wdata);
        end
      end else begin
        in_req = 0;
      end
      if (o_Done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(o_Done), 32'd0);
        end else begin
          got = sb.pop_front();
          chk("rdata", o_RData, got.rdata);
          chk("exc", 32'(o_Exc), 32'(got.exc));
          chk("done_cycle", 32'(cyc), 32'(got.cyc));
          chk("ready_in_done", 32'(o_Ready), 32'd0);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge i_Clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(negedge i_Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ld, st;
    logic [2:0] f3;
    logic [31:0] a;
    int d;
    repeat (3) @(negedge i_Clk);
    chk("rst_ready", 32'(o_Ready), 32'd1);
    chk("rst_done", 32'(o_Done), 32'd0);
    chk("rst_req", 32'(o_MemReq), 32'd0);
    chk("rst_we", 32'(o_MemWe), 32'd0);
    chk("rst_rdata", o_RData, 32'h0);
    chk("rst_exc", 32'(o_Exc), 32'd0);
    chk("rst_addr", o_MemAddr, 32'h0);
    chk("rst_wdata", o_MemWData, 32'h0);
    chk("rst_be", 32'(o_MemBe), 32'd0);
    i_Rst_n = 1'b1;
    mon_en  = 1;
    @(negedge i_Clk);

    issue(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0);
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 0, 32'h8011_2233);
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 1, 32'h8011_2233);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h0000_ABCD, 2, 32'h0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h0);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0300, 32'h0, 20, 32'h1234_5678);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0, T - 1, 32'h8765_4321);
    issue(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 0, 32'hCAFE_F00D);
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 0, 32'h0);
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0010, 32'h0, 0, 32'h0);
    issue(1'b1, 1'b0, 3'b110, 32'h0000_0010, 32'h0, 0, 32'h0);
    drain();

    for (int i = 0; i < 200; i++) begin
      if (($urandom % 10) == 0) begin
        ld = 1'($urandom);
        st = 1'($urandom);
        f3 = 3'($urandom);
      end else begin
        ld = 1'($urandom);
        st = !ld;
        f3 = ld ? lf[$urandom % 5] : 3'($urandom % 3);
      end
      a = $urandom;
      if (($urandom % 4) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      d = (($urandom % 8) == 0) ? 14 + int'($urandom % 5)
                                : int'($urandom % 4);
      issue(ld, st, f3, a, $urandom, d, $urandom);
      if (($urandom % 4) == 0) @(negedge i_Clk);
    end
    drain();

    issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 10, 32'h1111_2222);
    void'(sb.pop_back());
    chk("req_before_rst", 32'(o_MemReq), 32'd1);
    i_Rst_n  = 1'b0;
    late_ack = 1;
    @(negedge i_Clk);
    chk("rst_drop_req", 32'(o_MemReq), 32'd0);
    chk("rst_ready", 32'(o_Ready), 32'd1);
    chk("rst_no_done", 32'(o_Done), 32'd0);
    i_Rst_n = 1'b1;
    repeat (3) begin
      @(negedge i_Clk);
      chk("late_ack_no_req", 32'(o_MemReq), 32'd0);
      chk("late_ack_no_done", 32'(o_Done), 32'd0);
    end
    late_ack = 0;
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0502, 32'h0, 1, 32'hBEEF_0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
